// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer between fetch and execute.
// Decoded {Imm, tag, illegal} is captured at push; flush empties the buffer synchronously.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [2:0]       immSrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  Imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             illegal
);

   // state   | meaning
   // S_EMPTY | no entry held; head registers are stale
   // S_ONE   | head valid and presented; skid empty
   // S_FULL  | head presented, skid holds the next entry; in_ready low
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

   if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
   end

   state_t           r_state, w_state_nxt;
   logic [XLEN-1:0]  r_head_imm, r_skid_imm, w_imm;
   logic [TAG_W-1:0] r_head_tag, r_skid_tag;
   logic             r_head_ill, r_skid_ill, w_ill;
   logic [31:0]      w_val32;
   logic             w_push, w_pop;
   logic             w_load_head_in, w_load_head_skid, w_load_skid;
   logic             w_unused_opcode;

   assign w_unused_opcode = &{1'b0, instr[6:0]};

   // Every format fits in 32 bits; a signed size cast then extends to XLEN.
   always_comb begin
      w_val32 = 32'b0;
      w_ill   = 1'b0;
      case (immSrc)
         3'b000:  w_val32 = {{20{instr[31]}}, instr[31:20]};
         3'b001:  w_val32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         3'b010:  w_val32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         3'b011:  w_val32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         3'b100:  w_val32 = {instr[31:12], 12'b0};
         3'b101:  w_val32 = {27'b0, instr[19:15]};
         3'b110:  w_val32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
         default: w_ill   = 1'b1;
      endcase
      w_imm = XLEN'($signed(w_val32));
   end

   assign in_ready  = (r_state != S_FULL);
   assign out_valid = (r_state != S_EMPTY);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_head_in   = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_push) begin
               w_state_nxt    = S_ONE;
               w_load_head_in = 1'b1;
            end
         end
         S_ONE: begin
            if (w_push && w_pop) begin
               w_load_head_in = 1'b1;
            end else if (w_push) begin
               w_state_nxt = S_FULL;
               w_load_skid = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_pop) begin
               w_state_nxt      = S_ONE;
               w_load_head_skid = 1'b1;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      if (flush) begin
         w_state_nxt      = S_EMPTY;
         w_load_head_in   = 1'b0;
         w_load_head_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head_imm <= '0;
         r_head_tag <= '0;
         r_head_ill <= 1'b0;
         r_skid_imm <= '0;
         r_skid_tag <= '0;
         r_skid_ill <= 1'b0;
      end else begin
         if (w_load_head_in) begin
            r_head_imm <= w_imm;
            r_head_tag <= in_tag;
            r_head_ill <= w_ill;
         end else if (w_load_head_skid) begin
            r_head_imm <= r_skid_imm;
            r_head_tag <= r_skid_tag;
            r_head_ill <= r_skid_ill;
         end
         if (w_load_skid) begin
            r_skid_imm <= w_imm;
            r_skid_tag <= in_tag;
            r_skid_ill <= w_ill;
         end
      end
   end

   assign Imm     = r_head_imm;
   assign out_tag = r_head_tag;
   assign illegal = r_head_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, directed vectors.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_illegal;
   logic [31:0] a_instr = 0;
   logic [2:0]  a_immSrc = 0;
   logic [4:0]  a_in_tag = 0, a_out_tag;
   logic [31:0] a_Imm;

   logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_illegal;
   logic [31:0] b_instr = 0;
   logic [2:0]  b_immSrc = 0;
   logic [4:0]  b_in_tag = 0, b_out_tag;
   logic [63:0] b_Imm;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .instr(a_instr), .immSrc(a_immSrc),
      .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .Imm(a_Imm), .out_tag(a_out_tag), .illegal(a_illegal));

   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr), .immSrc(b_immSrc),
      .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .Imm(b_Imm), .out_tag(b_out_tag), .illegal(b_illegal));

   typedef struct packed {
      logic [63:0] imm;
      logic [4:0]  tag;
      logic        ill;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int checks = 0;
   int errors = 0;
   int pa_cnt = 0;
   int pa_last = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every presented-and-accepted entry against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && a_out_valid && a_out_ready) begin
         pa_cnt++;
         pa_last = cyc;
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_pop got tag %0d expected none", a_out_tag);
         end else begin
            e = qa.pop_front();
            chk("a_imm", {32'b0, a_Imm}, e.imm);
            chk("a_tag", {59'b0, a_out_tag}, {59'b0, e.tag});
            chk("a_illegal", {63'b0, a_illegal}, {63'b0, e.ill});
         end
      end
      if (rst_n && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_pop got tag %0d expected none", b_out_tag);
         end else begin
            e = qb.pop_front();
            chk("b_imm", b_Imm, e.imm);
            chk("b_tag", {59'b0, b_out_tag}, {59'b0, e.tag});
            chk("b_illegal", {63'b0, b_illegal}, {63'b0, e.ill});
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input bit d, input logic [31:0] ins, input logic [2:0] src,
                       input logic [4:0] tag, input logic [63:0] ei, input logic ill,
                       output int waits);
      exp_t e;
      e = {ei, tag, ill};
      waits = 0;
      if (d) begin
         b_in_valid = 1; b_instr = ins; b_immSrc = src; b_in_tag = tag;
      end else begin
         a_in_valid = 1; a_instr = ins; a_immSrc = src; a_in_tag = tag;
      end
      forever begin
         @(negedge clk);
         if (d ? b_in_ready : a_in_ready) begin
            if (d) qb.push_back(e);
            else qa.push_back(e);
            break;
         end
         if (waits == 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got no in_ready for tag %0d expected accept", tag);
            break;
         end
         waits++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      a_in_valid = 0;
      b_in_valid = 0;
   endtask

   logic [31:0] v_ins [9] = '{32'hFFF00093, 32'hFE112E23, 32'h80000063, 32'h800000EF, 32'h0010006F,
                               32'h12345037, 32'h000FD073, 32'h03F09093, 32'hFFFFFFFF};
   logic [2:0]  v_src [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [31:0] v_exp [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFF000, 32'hFFF00000, 32'h00000800,
                               32'h12345000, 32'h0000001F, 32'h0000001F, 32'h00000000};

   logic [31:0] w_ins [4] = '{32'h80000037, 32'h03F09093, 32'hFFFFFFFF, 32'hFFF00093};
   logic [2:0]  w_src [4] = '{3'd4, 3'd6, 3'd7, 3'd0};
   logic [63:0] w_exp [4] = '{64'hFFFFFFFF80000000, 64'h000000000000003F, 64'h0, 64'hFFFFFFFFFFFFFFFF};

   initial begin
      int w, start, cnt0;
      #1 rst_n = 0;
      #1;
      chk("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
      chk("rst_in_ready", {63'b0, a_in_ready}, 64'd1);
      chk("rst_imm", {32'b0, a_Imm}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;

      // Format decode and N+1 latency, XLEN=32
      a_out_ready = 1;
      for (int i = 0; i < 9; i++) begin
         push(0, v_ins[i], v_src[i], 5'(i), {32'b0, v_exp[i]}, (i == 8), w);
         @(negedge clk);
         chk("a_latency", {63'b0, a_out_valid}, 64'd1);
         @(posedge clk); #1;
      end

      // XLEN=64 formats
      for (int i = 0; i < 4; i++) begin
         push(1, w_ins[i], w_src[i], 5'(i + 16), w_exp[i], (i == 2), w);
         @(negedge clk);
         chk("b_latency", {63'b0, b_out_valid}, 64'd1);
         @(posedge clk); #1;
      end

      // Backpressure: third push stalls until the consumer drains
      a_out_ready = 0;
      push(0, 32'h00100093, 3'd0, 5'd1, 64'd1, 0, w);
      push(0, 32'h00200093, 3'd0, 5'd2, 64'd2, 0, w);
      chk("bp_second_no_wait", w, 0);
      a_in_valid = 1; a_instr = 32'h00300093; a_immSrc = 3'd0; a_in_tag = 5'd3;
      @(negedge clk);
      chk("bp_in_ready_low", {63'b0, a_in_ready}, 64'd0);
      chk("bp_out_valid", {63'b0, a_out_valid}, 64'd1);
      chk("bp_hold_tag", {59'b0, a_out_tag}, 64'd1);
      @(posedge clk); #1;
      a_out_ready = 1;
      push(0, 32'h00300093, 3'd0, 5'd3, 64'd3, 0, w);
      repeat (4) @(posedge clk); #1;
      chk("bp_drain", qa.size(), 0);

      // Streaming at one entry per cycle
      start = cyc;
      cnt0 = pa_cnt;
      for (int i = 0; i < 20; i++) begin
         push(0, {12'(i + 40), 20'h00093}, 3'd0, 5'(i), 64'(i + 40), 0, w);
         chk("stream_no_stall", w, 0);
      end
      repeat (3) @(posedge clk); #1;
      chk("stream_pops", pa_cnt - cnt0, 20);
      chk("stream_span", pa_last - start, 20);

      // Flush while FULL with a coincident push
      a_out_ready = 0;
      push(0, 32'h00700093, 3'd0, 5'd7, 64'd7, 0, w);
      push(0, 32'h00800093, 3'd0, 5'd8, 64'd8, 0, w);
      a_in_valid = 1; a_instr = 32'h00900093; a_immSrc = 3'd0; a_in_tag = 5'd9;
      flush = 1;
      @(posedge clk); #1;
      qa.delete();
      flush = 0;
      a_in_valid = 0;
      @(negedge clk);
      chk("flush_out_valid", {63'b0, a_out_valid}, 64'd0);
      chk("flush_in_ready", {63'b0, a_in_ready}, 64'd1);
      @(posedge clk); #1;
      a_out_ready = 1;
      repeat (3) @(posedge clk); #1;
      push(0, 32'h00A00093, 3'd0, 5'd10, 64'd10, 0, w);
      @(negedge clk);
      chk("post_flush_latency", {63'b0, a_out_valid}, 64'd1);
      @(posedge clk); #1;

      // Asynchronous reset while FULL
      a_out_ready = 0;
      push(0, 32'hFFF00093, 3'd0, 5'd11, 64'hFFFFFFFF, 0, w);
      push(0, 32'h00C00093, 3'd0, 5'd12, 64'd12, 0, w);
      #2 rst_n = 0;
      #1;
      chk("arst_out_valid", {63'b0, a_out_valid}, 64'd0);
      chk("arst_imm", {32'b0, a_Imm}, 64'd0);
      chk("arst_tag", {59'b0, a_out_tag}, 64'd0);
      chk("arst_in_ready", {63'b0, a_in_ready}, 64'd1);
      qa.delete();
      qb.delete();
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      a_out_ready = 1;
      push(0, 32'h80000037, 3'd4, 5'd13, 64'h80000000, 0, w);
      @(negedge clk);
      chk("arst_push_latency", {63'b0, a_out_valid}, 64'd1);

      repeat (4) @(posedge clk); #1;
      chk("final_qa_empty", qa.size(), 0);
      chk("final_qb_empty", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
